// File: rtl/usb_line_tx.sv
// Full-speed USB line transmitter: serialises packet bytes into SYNC, NRZI data with
// bit stuffing and EOP on the D+/D- pair, paced by an internal bit-rate divider.
module usb_line_tx #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic       hi_clock,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  output logic       tx_plus,
  output logic       tx_minus,
  output logic       tx_oe,
  output logic       tx_busy,
  output logic       tx_err
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {StIdle, StSync, StData, StEopSe0, StEopJ} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [2:0]      ones_q, ones_d;
  logic [7:0]      shift_q, shift_d;
  logic [7:0]      hold_q, hold_d;
  logic            hold_last_q, hold_last_d;
  logic            hold_full_q, hold_full_d;
  logic            cur_last_q, cur_last_d;
  logic            closed_q, closed_d;
  logic            plus_q, plus_d;
  logic            minus_q, minus_d;
  logic            oe_q, oe_d;
  logic            err_q, err_d;

  logic            xfer;
  logic            wrap;
  logic            send_en;
  logic            send_bit;
  logic [7:0]      nxt_byte;
  logic            nxt_last;

  // closed_q blocks further bytes once the packet has been terminated (last byte or underrun)
  assign tx_ready = ~reset & ~hold_full_q & ~closed_q;
  assign xfer     = tx_valid & tx_ready;
  assign wrap     = (cnt_q == CntMax);

  assign tx_plus  = plus_q;
  assign tx_minus = minus_q;
  assign tx_oe    = oe_q;
  assign tx_err   = err_q;
  assign tx_busy  = (state_q != StIdle);

  // Next-state, holding register and next line level, evaluated at each bit boundary
  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? '0 : cnt_q + CntW'(1);
    idx_d       = idx_q;
    ones_d      = ones_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_last_d = hold_last_q;
    hold_full_d = hold_full_q;
    cur_last_d  = cur_last_q;
    closed_d    = closed_q;
    plus_d      = plus_q;
    minus_d     = minus_q;
    oe_d        = oe_q;
    err_d       = 1'b0;
    send_en     = 1'b0;
    send_bit    = 1'b0;
    // A byte arriving on the very cycle of a byte boundary is used directly
    nxt_byte    = hold_full_q ? hold_q : tx_data;
    nxt_last    = hold_full_q ? hold_last_q : tx_last;

    if (xfer) begin
      hold_d      = tx_data;
      hold_last_d = tx_last;
      hold_full_d = 1'b1;
      if (tx_last) closed_d = 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (hold_full_q) begin
          state_d  = StSync;
          idx_d    = 3'd0;
          oe_d     = 1'b1;
          send_en  = 1'b1;
          send_bit = 1'b0;
        end
      end
      StSync: begin
        if (wrap) begin
          send_en = 1'b1;
          if (idx_q != 3'd7) begin
            idx_d    = idx_q + 3'd1;
            send_bit = (idx_q == 3'd6);
          end else begin
            state_d     = StData;
            idx_d       = 3'd0;
            shift_d     = hold_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            send_bit    = hold_q[0];
          end
        end
      end
      StData: begin
        if (wrap) begin
          if (ones_q == 3'd6) begin
            // Stuff bit: data index does not advance
            send_en  = 1'b1;
            send_bit = 1'b0;
          end else if (idx_q != 3'd7) begin
            send_en  = 1'b1;
            idx_d    = idx_q + 3'd1;
            shift_d  = {1'b0, shift_q[7:1]};
            send_bit = shift_q[1];
          end else if (cur_last_q) begin
            state_d = StEopSe0;
            idx_d   = 3'd0;
            plus_d  = 1'b0;
            minus_d = 1'b0;
          end else if (hold_full_q || xfer) begin
            send_en     = 1'b1;
            idx_d       = 3'd0;
            shift_d     = nxt_byte;
            cur_last_d  = nxt_last;
            hold_full_d = 1'b0;
            send_bit    = nxt_byte[0];
          end else begin
            err_d    = 1'b1;
            closed_d = 1'b1;
            state_d  = StEopSe0;
            idx_d    = 3'd0;
            plus_d   = 1'b0;
            minus_d  = 1'b0;
          end
        end
      end
      StEopSe0: begin
        if (wrap) begin
          if (idx_q == 3'd1) begin
            state_d = StEopJ;
            idx_d   = 3'd0;
            plus_d  = 1'b1;
            minus_d = 1'b0;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StEopJ: begin
        if (wrap) begin
          state_d  = StIdle;
          oe_d     = 1'b0;
          closed_d = 1'b0;
          plus_d   = 1'b1;
          minus_d  = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // NRZI: a 0 toggles the line, a 1 holds it; the ones run tracks stuffing
    if (send_en) begin
      plus_d  = send_bit ? plus_q : ~plus_q;
      minus_d = ~plus_d;
      ones_d  = send_bit ? ones_q + 3'd1 : 3'd0;
    end
  end

  // State and registered line outputs
  always_ff @(posedge hi_clock or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      ones_q      <= 3'd0;
      shift_q     <= 8'h00;
      hold_q      <= 8'h00;
      hold_last_q <= 1'b0;
      hold_full_q <= 1'b0;
      cur_last_q  <= 1'b0;
      closed_q    <= 1'b0;
      plus_q      <= 1'b1;
      minus_q     <= 1'b0;
      oe_q        <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_last_q <= hold_last_d;
      hold_full_q <= hold_full_d;
      cur_last_q  <= cur_last_d;
      closed_q    <= closed_d;
      plus_q      <= plus_d;
      minus_q     <= minus_d;
      oe_q        <= oe_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_usb_line_tx.sv
// Self-checking bench for usb_line_tx: table-driven packets, random packets against a
// bit-stream reference model, and a mid-packet reset sequence.
module tb_usb_line_tx;

  localparam int Cpb = 4;
  localparam logic [31:0] None = 32'hFFFF_FFFF;

  logic       hi_clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_ready, tx_plus, tx_minus, tx_oe, tx_busy, tx_err;

  usb_line_tx #(.CLKS_PER_BIT(Cpb)) dut (
    .hi_clock (hi_clock),
    .reset    (reset),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_last  (tx_last),
    .tx_ready (tx_ready),
    .tx_plus  (tx_plus),
    .tx_minus (tx_minus),
    .tx_oe    (tx_oe),
    .tx_busy  (tx_busy),
    .tx_err   (tx_err)
  );

  always #5 hi_clock = ~hi_clock;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] bytes;     // byte i in bits [8*i +: 8]
    int          drop;      // >=0: valid dropped after this byte index (underrun)
    int          exp_bits;  // expected bit times, -1 = from model only
    int          exp_err;
  } vec_t;

  int n_err = 0;
  int n_checks = 0;

  logic [1:0] cap [$];      // {plus,minus} per cycle while tx_oe
  int         err_idx [$];
  logic [1:0] exp_q [$];
  int         acc_cnt = 0;
  int         idle_bad = 0;
  int         busy_bad = 0;

  // Line capture on the falling edge, away from the active edge
  always @(negedge hi_clock) begin
    if (!reset) begin
      if (tx_oe) begin
        if (tx_err) err_idx.push_back(cap.size());
        cap.push_back({tx_plus, tx_minus});
      end else if (!(tx_plus && !tx_minus) || tx_err) begin
        idle_bad++;
      end
      if (tx_busy !== tx_oe) busy_bad++;
    end
  end

  always @(posedge hi_clock) begin
    if (!reset && tx_valid && tx_ready) acc_cnt++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: timed out", name);
  endtask

  // Reference: SYNC bits, LSB-first data with a stuffed 0 after every six 1s, NRZI, EOP
  task automatic build_expected(input logic [31:0] bytes, input int n);
    bit   bits [$];
    int   ones;
    logic lvl;
    exp_q.delete();
    for (int i = 0; i < 7; i++) bits.push_back(1'b0);
    bits.push_back(1'b1);
    ones = 1;
    for (int b = 0; b < n; b++) begin
      for (int k = 0; k < 8; k++) begin
        bit d;
        d = bytes[8*b + k];
        bits.push_back(d);
        ones = d ? ones + 1 : 0;
        if (ones == 6) begin
          bits.push_back(1'b0);
          ones = 0;
        end
      end
    end
    lvl = 1'b1;
    foreach (bits[i]) begin
      if (!bits[i]) lvl = ~lvl;
      for (int c = 0; c < Cpb; c++) exp_q.push_back({lvl, ~lvl});
    end
    for (int c = 0; c < 2 * Cpb; c++) exp_q.push_back(2'b00);
    for (int c = 0; c < Cpb; c++) exp_q.push_back(2'b10);
  endtask

  task automatic send_bytes(input string name, input logic [31:0] bytes, input int n,
                            input bit mark_last);
    int guard;
    @(posedge hi_clock);
    #1;
    for (int i = 0; i < n; i++) begin
      tx_data  = bytes[8*i +: 8];
      tx_last  = mark_last && (i == n - 1);
      tx_valid = 1'b1;
      guard = 0;
      do begin
        @(negedge hi_clock);
        guard++;
      end while (!tx_ready && guard < 2000);
      if (!tx_ready) timeout({name, "_accept"});
      @(posedge hi_clock);
      #1;
    end
    tx_valid = 1'b0;
    tx_last  = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int guard = 0;
    do begin
      @(negedge hi_clock);
      #1;
      guard++;
    end while (!(cap.size() > 0 && !tx_oe) && guard < 3000);
    if (tx_oe || cap.size() == 0) timeout({name, "_end"});
    repeat (2) @(negedge hi_clock);
  endtask

  task automatic run_case(input vec_t v);
    int          nsent;
    int          guard;
    logic [31:0] first_bad;
    nsent = (v.drop >= 0) ? v.drop + 1 : v.n;
    cap.delete();
    err_idx.delete();
    acc_cnt  = 0;
    idle_bad = 0;
    busy_bad = 0;
    check({v.name, "_ready_idle"}, {31'd0, tx_ready}, 32'd1);
    send_bytes(v.name, v.bytes, nsent, v.drop < 0);
    if (v.drop >= 0) begin
      guard = 0;
      while (err_idx.size() == 0 && guard < 2000) begin
        @(negedge hi_clock);
        #1;
        guard++;
      end
      if (err_idx.size() == 0) timeout({v.name, "_err_wait"});
      // Late byte offered during EOP must not be taken
      tx_data  = v.bytes[8*(v.drop+1) +: 8];
      tx_last  = 1'b1;
      tx_valid = 1'b1;
      repeat (4) @(posedge hi_clock);
      #1;
      tx_valid = 1'b0;
      tx_last  = 1'b0;
    end
    wait_end(v.name);
    build_expected(v.bytes, nsent);
    first_bad = None;
    for (int i = 0; i < cap.size() && i < exp_q.size(); i++) begin
      if (cap[i] !== exp_q[i] && first_bad == None) first_bad = i;
    end
    check({v.name, "_len_model"}, cap.size(), exp_q.size());
    if (v.exp_bits >= 0) check({v.name, "_len_bits"}, cap.size(), v.exp_bits * Cpb);
    check({v.name, "_line_first_bad_cycle"}, first_bad, None);
    check({v.name, "_err_count"}, err_idx.size(), v.exp_err);
    if (v.exp_err > 0 && err_idx.size() > 0)
      check({v.name, "_err_pos"}, err_idx[0], exp_q.size() - 3 * Cpb);
    check({v.name, "_accepts"}, acc_cnt, nsent);
    check({v.name, "_idle_line"}, idle_bad, 0);
    check({v.name, "_busy_eq_oe"}, busy_bad, 0);
  endtask

  vec_t vecs [5];
  vec_t rv;

  initial begin
    vecs[0] = '{name: "ack_d2",   n: 1, bytes: 32'h0000_00D2, drop: -1, exp_bits: 19, exp_err: 0};
    vecs[1] = '{name: "ff_stuff", n: 1, bytes: 32'h0000_00FF, drop: -1, exp_bits: 20, exp_err: 0};
    vecs[2] = '{name: "fc_tail",  n: 1, bytes: 32'h0000_00FC, drop: -1, exp_bits: 20, exp_err: 0};
    vecs[3] = '{name: "three",    n: 3, bytes: 32'h0003_0201, drop: -1, exp_bits: 35, exp_err: 0};
    vecs[4] = '{name: "underrun", n: 2, bytes: 32'h0000_5AA5, drop: 0,  exp_bits: 19, exp_err: 1};

    // Reset state
    @(negedge hi_clock);
    check("rst_plus",  {31'd0, tx_plus},  32'd1);
    check("rst_minus", {31'd0, tx_minus}, 32'd0);
    check("rst_oe",    {31'd0, tx_oe},    32'd0);
    check("rst_busy",  {31'd0, tx_busy},  32'd0);
    check("rst_err",   {31'd0, tx_err},   32'd0);
    check("rst_ready", {31'd0, tx_ready}, 32'd0);
    @(negedge hi_clock);
    reset = 1'b0;
    repeat (2) @(negedge hi_clock);

    foreach (vecs[i]) run_case(vecs[i]);

    // Random packets against the reference model, contiguous supply
    for (int r = 0; r < 6; r++) begin
      rv.name = $sformatf("rand%0d", r);
      rv.n = $urandom_range(1, 4);
      for (int b = 0; b < 4; b++)
        rv.bytes[8*b +: 8] = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
      rv.drop = -1;
      rv.exp_bits = -1;
      rv.exp_err = 0;
      repeat ($urandom_range(0, 5)) @(negedge hi_clock);
      run_case(rv);
    end

    // Reset during DATA bit 3 of an ACK
    cap.delete();
    send_bytes("midrst", 32'h0000_00D2, 1, 1'b1);
    begin
      int guard = 0;
      while (cap.size() < 46 && guard < 2000) begin
        @(negedge hi_clock);
        #1;
        guard++;
      end
      if (cap.size() < 46) timeout("midrst_wait");
    end
    reset = 1'b1;
    #1;
    check("midrst_plus",  {31'd0, tx_plus},  32'd1);
    check("midrst_minus", {31'd0, tx_minus}, 32'd0);
    check("midrst_oe",    {31'd0, tx_oe},    32'd0);
    check("midrst_busy",  {31'd0, tx_busy},  32'd0);
    check("midrst_err",   {31'd0, tx_err},   32'd0);
    check("midrst_ready", {31'd0, tx_ready}, 32'd0);
    repeat (3) @(negedge hi_clock);
    reset = 1'b0;
    repeat (2) @(negedge hi_clock);
    rv = vecs[0];
    rv.name = "after_rst";
    run_case(rv);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
